// File: rtl/cpu_cond_pkg.sv
// Shared types for the branch/flag path: condition codes, branch kinds and
// the NZCV flag bundle.
package cpu_cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    BR_B    = 2'd0,
    BR_CBZ  = 2'd1,
    BR_CBNZ = 2'd2,
    BR_COND = 2'd3
  } br_type_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARMv8 condition-code evaluator over an NZCV bundle.
// Kept standalone so a conditional-select unit can reuse it.
module cond_eval
  import cpu_cond_pkg::*;
(
  input  nzcv_t flags,
  input  cond_e cond,
  output logic  taken
);

  // condition truth table; AL and NV both resolve to always-true
  always_comb begin
    taken = 1'b0;
    case (cond)
      EQ:      taken = flags.z;
      NE:      taken = ~flags.z;
      HS:      taken = flags.c;
      LO:      taken = ~flags.c;
      MI:      taken = flags.n;
      PL:      taken = ~flags.n;
      VS:      taken = flags.v;
      VC:      taken = ~flags.v;
      HI:      taken = flags.c & ~flags.z;
      LS:      taken = ~(flags.c & ~flags.z);
      GE:      taken = (flags.n == flags.v);
      LT:      taken = (flags.n != flags.v);
      GT:      taken = ~flags.z & (flags.n == flags.v);
      LE:      taken = ~(~flags.z & (flags.n == flags.v));
      AL:      taken = 1'b1;
      NV:      taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Architectural NZCV register plus registered branch resolution for fetch,
// with same-cycle flag forwarding and saturating branch statistics.
module branch_cond_unit
  import cpu_cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_neg,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  input  logic             set_flags,
  input  logic             stall,
  input  logic             flush,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic [3:0]       br_cond,
  input  logic             rt_zero,
  output logic [3:0]       flags_q,
  output logic             br_done,
  output logic             br_taken,
  output logic [CNT_W-1:0] cnt_eval,
  output logic [CNT_W-1:0] cnt_taken
);

  nzcv_t      flags;
  nzcv_t      alu_flags;
  nzcv_t      eff_flags;
  logic       cond_taken;
  logic       decision;
  logic [CNT_W-1:0] eval_next;
  logic [CNT_W-1:0] taken_next;

  assign alu_flags = '{n: alu_neg, z: alu_zero, c: alu_carry, v: alu_ovf};
  // a branch in the same cycle as a flag write must see the new flags
  assign eff_flags = set_flags ? alu_flags : flags;
  assign flags_q   = flags;

  cond_eval u_cond_eval (
    .flags (eff_flags),
    .cond  (cond_e'(br_cond)),
    .taken (cond_taken)
  );

  // branch kind selects between register zero-test and condition code
  always_comb begin
    decision = 1'b0;
    case (br_type_e'(br_type))
      BR_B:    decision = 1'b1;
      BR_CBZ:  decision = rt_zero;
      BR_CBNZ: decision = ~rt_zero;
      BR_COND: decision = cond_taken;
      default: decision = 1'b0;
    endcase
  end

  // saturating next values for the statistics counters
  always_comb begin
    if (&cnt_eval) begin
      eval_next = cnt_eval;
    end else begin
      eval_next = cnt_eval + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (decision && !(&cnt_taken)) begin
      taken_next = cnt_taken + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      taken_next = cnt_taken;
    end
  end

  // flag register, decision register and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      flags     <= '{n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};
      br_done   <= 1'b0;
      br_taken  <= 1'b0;
      cnt_eval  <= {CNT_W{1'b0}};
      cnt_taken <= {CNT_W{1'b0}};
    end else if (flush) begin
      br_done <= 1'b0;
    end else if (!stall) begin
      if (set_flags) begin
        flags <= alu_flags;
      end
      if (br_valid) begin
        br_done   <= 1'b1;
        br_taken  <= decision;
        cnt_eval  <= eval_next;
        cnt_taken <= taken_next;
      end else begin
        br_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Randomized and directed bench for branch_cond_unit against an
// arithmetic reference model of the flag register and branch rules.
module tb_branch_cond_unit;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset, alu_neg, alu_zero, alu_carry, alu_ovf, set_flags;
  logic stall, flush, br_valid, rt_zero;
  logic [1:0] br_type;
  logic [3:0] br_cond;
  logic [3:0] flags_q;
  logic br_done, br_taken;
  logic [CNT_W-1:0] cnt_eval, cnt_taken;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  int m_flags = 0;
  int m_done  = 0;
  int m_taken = 0;
  int m_eval  = 0;
  int m_tk    = 0;

  always #5 clk = ~clk;

  branch_cond_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .set_flags(set_flags), .stall(stall), .flush(flush),
    .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond), .rt_zero(rt_zero),
    .flags_q(flags_q), .br_done(br_done), .br_taken(br_taken),
    .cnt_eval(cnt_eval), .cnt_taken(cnt_taken)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // condition codes come in true/inverted pairs; 14 and 15 are always true
  function automatic int ref_cond(input int cond, input int f);
    int n, z, c, v, r;
    n = (f >> 3) & 1; z = (f >> 2) & 1; c = (f >> 1) & 1; v = f & 1;
    case (cond / 2)
      0: r = z;
      1: r = c;
      2: r = n;
      3: r = v;
      4: r = (c == 1 && z == 0) ? 1 : 0;
      5: r = (n == v) ? 1 : 0;
      6: r = (z == 0 && n == v) ? 1 : 0;
      default: r = 1;
    endcase
    if ((cond % 2) == 1 && cond != 15) r = 1 - r;
    return r;
  endfunction

  task automatic cycle(input logic rst, input logic sf, input logic [3:0] f,
                       input logic stl, input logic fl, input logic bv,
                       input logic [1:0] bt, input logic [3:0] bc, input logic rz);
    int eff, dec;
    reset = rst; set_flags = sf;
    {alu_neg, alu_zero, alu_carry, alu_ovf} = f;
    stall = stl; flush = fl; br_valid = bv; br_type = bt; br_cond = bc; rt_zero = rz;
    @(posedge clk);
    if (rst) begin
      m_flags = 0; m_done = 0; m_taken = 0; m_eval = 0; m_tk = 0;
    end else if (fl) begin
      m_done = 0;
    end else if (!stl) begin
      eff = sf ? int'(f) : m_flags;
      if (sf) m_flags = int'(f);
      if (bv) begin
        case (int'(bt))
          0: dec = 1;
          1: dec = int'(rz);
          2: dec = 1 - int'(rz);
          default: dec = ref_cond(int'(bc), eff);
        endcase
        m_done = 1; m_taken = dec;
        if (m_eval < CMAX) m_eval++;
        if (dec == 1 && m_tk < CMAX) m_tk++;
      end else begin
        m_done = 0;
      end
    end
    @(negedge clk);
    check("flags_q",   32'(flags_q),   32'(m_flags));
    check("br_done",   32'(br_done),   32'(m_done));
    check("br_taken",  32'(br_taken),  32'(m_taken));
    check("cnt_eval",  32'(cnt_eval),  32'(m_eval));
    check("cnt_taken", 32'(cnt_taken), 32'(m_tk));
  endtask

  initial begin
    @(negedge clk);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    check("reset_flags", 32'(flags_q), 32'h0);
    // SUBS Z=1,C=1 with B.EQ in the same cycle
    cycle(1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 2'd3, 4'h0, 1'b0);
    check("fwd_eq_taken", 32'(br_taken), 32'h1);
    check("fwd_flags", 32'(flags_q), 32'h6);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd3, 4'hC, 1'b0);
    check("gt_not_taken", 32'(br_taken), 32'h0);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd3, 4'h2, 1'b0);
    check("hs_taken", 32'(br_taken), 32'h1);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd3, 4'hE, 1'b0);
    check("al_taken", 32'(br_taken), 32'h1);
    // N=1,V=0 then LT / GE / CBZ
    cycle(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd3, 4'hB, 1'b0);
    check("lt_taken", 32'(br_taken), 32'h1);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd3, 4'hA, 1'b0);
    check("ge_not_taken", 32'(br_taken), 32'h0);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd1, 4'h0, 1'b1);
    check("cbz_taken", 32'(br_taken), 32'h1);
    check("cbz_flags", 32'(flags_q), 32'h8);
    // flush cancels flag write and branch
    cycle(1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 4'h0, 1'b0);
    check("flush_done", 32'(br_done), 32'h0);
    check("flush_flags", 32'(flags_q), 32'h8);
    check("flush_eval", 32'(cnt_eval), 32'h7);
    // done pulse held through stall
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd2, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 2'd0, 4'h0, 1'b0);
      check("stall_done", 32'(br_done), 32'h1);
    end
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    check("release_done", 32'(br_done), 32'h0);
    // saturation
    for (int i = 0; i < 20; i++)
      cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 4'h0, 1'b0);
    check("sat_eval", 32'(cnt_eval), 32'hF);
    check("sat_taken", 32'(cnt_taken), 32'hF);
    cycle(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 4'h0, 1'b0);
    check("rst_all", {27'd0, flags_q, br_done}, 32'h0);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Consumer side of the ALU zero/flag path. Holds the architectural NZCV register, updated by flag-setting ALU ops (ADDS/SUBS/ANDS). Resolves B, B.cond, CBZ and CBNZ into a registered taken/not-taken decision for the fetch stage. Forwards same-cycle flag writes to the branch evaluation and keeps saturating branch statistics.

## Interface
Parameters:
- CNT_W, 16, width of the saturating statistics counters

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- alu_neg  in  1  N from current ALU result (bit 63)
- alu_zero  in  1  Z from current ALU result (64-bit all-zero detect)
- alu_carry  in  1  C from current ALU adder carry-out
- alu_ovf  in  1  V from current ALU adder signed overflow
- set_flags  in  1  current ALU op writes NZCV
- stall  in  1  hold all state this cycle
- flush  in  1  cancel this cycle's flag write and branch request
- br_valid  in  1  branch request present this cycle
- br_type  in  2  0=B, 1=CBZ, 2=CBNZ, 3=B.cond
- br_cond  in  4  ARMv8 condition code (B.cond only)
- rt_zero  in  1  zero detect of CBZ/CBNZ register operand
- flags_q  out  4  architectural {N,Z,C,V}
- br_done  out  1  one-cycle pulse: decision valid
- br_taken  out  1  decision; meaningful only with br_done
- cnt_eval  out  CNT_W  branches resolved, saturating
- cnt_taken  out  CNT_W  branches taken, saturating

## Operation
- Priority per cycle: reset > flush > stall > normal.
- Effective flags: if set_flags=1, {alu_neg,alu_zero,alu_carry,alu_ovf}; else flags_q. Forwarding is mandatory: branch evaluated in the same cycle as a flag write sees the new flags.
- Normal: if set_flags, flags_q <= ALU flags. If br_valid: br_done <= 1, br_taken <= decision, cnt_eval += 1, cnt_taken += decision. Otherwise br_done <= 0; br_taken holds.
- Decision: B -> 1; CBZ -> rt_zero; CBNZ -> !rt_zero; B.cond -> cond(effective flags). CBZ/CBNZ ignore NZCV entirely.
- Conditions: 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !(C&!Z); A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE !(!Z&(N==V)); E, F always taken.
- Counters saturate at all-ones: no wrap. cnt_taken saturates independently of cnt_eval.
- Flush: no flag write, br_done <= 0, counters hold, flags_q holds.
- Stall: all registers hold, including br_done. A done pulse present on entry persists through the stall. Downstream qualifies it with its own stall.
- Reset: flags_q=4'b0000, br_done=0, br_taken=0, cnt_eval=0, cnt_taken=0. Takes effect at the next edge regardless of in-flight request.

## Timing
- Flag write latency: flags_q reflects new value 1 cycle after set_flags sampled.
- Branch latency: br_done/br_taken asserted the cycle after br_valid sampled. Back-to-back br_valid gives back-to-back br_done.
- Outputs are registered only. No combinational input-to-output path.
- Counters update on the same edge as the corresponding br_done.
- Simultaneous set_flags and br_valid: decision uses forwarded flags. flags_q and br_done both update on the same edge.

## Structure
- Shared package cpu_cond_pkg:
  - cond_e enum (EQ..NV, 4 bits)
  - br_type_e enum (BR_B, BR_CBZ, BR_CBNZ, BR_COND)
  - nzcv_t packed struct {n,z,c,v}
- Sub-module cond_eval: combinational (nzcv_t, cond_e) -> taken. Reused by a future conditional-select unit.
- Top holds flag register, forwarding mux, decision register and counters.

## Test plan
- Reset, then SUBS with ALU flags Z=1,C=1 and B.cond EQ in the same cycle -> next cycle br_done=1, br_taken=1, flags_q=4'b0110.
- flags_q=4'b0110, no set_flags, B.cond GT -> br_taken=0. B.cond HS -> br_taken=1. B.cond AL -> br_taken=1.
- N=1,V=0 written. Next cycle B.cond LT -> taken; then GE -> not taken. CBZ with rt_zero=1 -> taken and flags_q unchanged.
- br_valid with flush=1 and set_flags=1 -> br_done=0, flags_q unchanged, cnt_eval unchanged.
- br_done pulse followed by stall=1 for 3 cycles -> br_done stays 1 and counters hold. Stall released with no br_valid -> br_done=0.
- CNT_W=4, 20 taken B branches -> cnt_eval=cnt_taken=4'hF, no wrap. Then reset mid-stream -> all outputs 0 on next cycle.
